// File: rtl/eda_pkg.sv
// rtl/eda_pkg.sv - shared serializer state and 3x3 window offset helpers
package eda_pkg;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_SERIAL = 1'b1
  } ser_state_e;

  // Mask bit k skips the centre (window index 4) of the 3x3 window.
  function automatic int unsigned bit_to_win(input int unsigned k);
    return (k < 4) ? k : k + 1;
  endfunction

  function automatic int win_dr(input int unsigned w);
    return int'(w / 3) - 1;
  endfunction

  function automatic int win_dc(input int unsigned w);
    return int'(w % 3) - 1;
  endfunction

endpackage

// File: rtl/eda_global_define.svh
// rtl/eda_global_define.svh - global image/window configuration macros
`ifndef EDA_GLOBAL_DEFINE_SVH
`define EDA_GLOBAL_DEFINE_SVH

`define CFG_M            64
`define CFG_N            64
`define CFG_ADDR_WIDTH   12
`define CFG_WINDOW_WIDTH 9

`endif

// File: rtl/eda_sync_fifo.sv
// rtl/eda_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module eda_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Reads never bypass an empty FIFO; a write into a full FIFO needs a same-cycle read.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/eda_push_queue.sv
// rtl/eda_push_queue.sv - serializes a 3x3 neighbour mask into a queue of pixel addresses
`include "eda_global_define.svh"

module eda_push_queue
  import eda_pkg::*;
#(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int ADDR_WIDTH   = `CFG_ADDR_WIDTH,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int QUEUE_DEPTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [WINDOW_WIDTH-2:0]          push_positions,
  input  logic [ADDR_WIDTH-1:0]            center_addr,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [ADDR_WIDTH-1:0]            pop_addr,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] count,
  output logic                             overflow
);

  localparam int PW = WINDOW_WIDTH - 1;

  if (M * N > (1 << ADDR_WIDTH)) begin : g_addr_too_narrow
    $error("eda_push_queue: ADDR_WIDTH cannot address an M x N image");
  end

  ser_state_e            state_q;
  logic [PW-1:0]         mask_q, mask_d;
  logic [ADDR_WIDTH-1:0] center_q;
  logic                  overflow_q;

  logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PW-1:0]         low_onehot;
  logic                  last_bit, accept, new_mask;
  int                    low_idx;
  int                    offset;

  always_comb begin
    low_idx = 0;
    for (int k = PW - 1; k >= 0; k--) begin
      if (mask_q[k]) low_idx = k;
    end
  end

  // Neighbour offset wraps modulo 2**ADDR_WIDTH; the mask already excludes off-image pixels.
  always_comb begin
    offset  = win_dr(bit_to_win(unsigned'(low_idx))) * N
            + win_dc(bit_to_win(unsigned'(low_idx)));
    wr_addr = center_q + ADDR_WIDTH'(offset);
  end

  assign low_onehot = mask_q & (~mask_q + PW'(1));
  assign mask_d     = mask_q & ~low_onehot;
  assign last_bit   = (mask_d == '0);

  assign fifo_rd    = pop_ready && !fifo_empty && !flush;
  assign fifo_wr    = (state_q == SER_SERIAL) && (!fifo_full || fifo_rd) && !flush;
  assign push_ready = (state_q == SER_IDLE) || (fifo_wr && last_bit);
  assign accept     = push_valid && push_ready;
  assign new_mask   = accept && (push_positions != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SER_IDLE;
      mask_q     <= '0;
      center_q   <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      state_q    <= SER_IDLE;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fifo_wr && fifo_full && !fifo_rd) overflow_q <= 1'b1;
      case (state_q)
        SER_IDLE: begin
          if (new_mask) begin
            mask_q   <= push_positions;
            center_q <= center_addr;
            state_q  <= SER_SERIAL;
          end
        end
        SER_SERIAL: begin
          if (fifo_wr) begin
            if (!last_bit) begin
              mask_q <= mask_d;
            end else if (new_mask) begin
              mask_q   <= push_positions;
              center_q <= center_addr;
            end else begin
              mask_q  <= '0;
              state_q <= SER_IDLE;
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

  eda_sync_fifo #(
    .WIDTH(ADDR_WIDTH),
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .wr_en  (fifo_wr),
    .wr_data(wr_addr),
    .rd_en  (fifo_rd),
    .rd_data(pop_addr),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign pop_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_eda_push_queue.sv
// tb/tb_eda_push_queue.sv - scoreboard bench for eda_push_queue
module tb_eda_push_queue;

  localparam int AW = 8;
  localparam int NN = 8;
  localparam int QD = 4;
  localparam int PW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [PW-1:0] push_positions = '0;
  logic [AW-1:0] center_addr = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [AW-1:0] pop_addr;
  logic [CW-1:0] count;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_q [$];
  bit            rand_pop = 1'b0;

  eda_push_queue #(
    .M(8), .N(NN), .ADDR_WIDTH(AW), .WINDOW_WIDTH(9), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_positions(push_positions), .center_addr(center_addr),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_addr(pop_addr),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: neighbours in ascending bit order, address = centre + dr*N + dc mod 2**AW.
  function automatic void model_push(input logic [AW-1:0] c, input logic [PW-1:0] m);
    for (int k = 0; k < PW; k++) begin
      if (m[k]) begin
        int w;
        int a;
        w = (k < 4) ? k : k + 1;
        a = int'(c) + (w / 3 - 1) * NN + (w % 3 - 1);
        exp_q.push_back(AW'(a));
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] c, input logic [PW-1:0] m);
    bit done;
    done = 1'b0;
    push_valid     = 1'b1;
    push_positions = m;
    center_addr    = c;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (push_ready) begin
        model_push(c, m);
        done = 1'b1;
      end
      step();
    end
    if (!done) check("push_timeout", 0, 1);
    push_valid     = 1'b0;
    push_positions = '0;
  endtask

  task automatic drain(input string name);
    pop_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if (!pop_valid && exp_q.size() == 0) break;
      step();
    end
    check({name, "_pop_valid"}, pop_valid, 0);
    check({name, "_model_left"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && !flush) begin
      check("overflow_low", overflow, 0);
      if (pop_valid && pop_ready) begin
        if (exp_q.size() == 0) check("pop_without_expected", 1, 0);
        else check("pop_addr", pop_addr, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_pop) begin
      #1;
      pop_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    check("rst_count", count, 0);
    check("rst_pop_valid", pop_valid, 0);
    step();
    reset_n = 1'b1;
    step();
    check("rel_push_ready", push_ready, 1);
    check("rel_count", count, 0);
    check("rel_overflow", overflow, 0);

    // Two-bit mask: 1 then 19
    pop_ready = 1'b0;
    push(8'd10, 8'b1000_0001);
    check("t1_latency_empty", pop_valid, 0);
    step();
    check("t1_count1", count, 1);
    check("t1_head", pop_addr, 1);
    step();
    check("t1_count2", count, 2);
    drain("t1");

    // Full mask with stalled consumer
    pop_ready = 1'b0;
    push(8'd10, 8'hFF);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t2_fill_count", count, i);
    end
    step();
    check("t2_stall_count", count, 4);
    check("t2_stall_ready", push_ready, 0);
    check("t2_head", pop_addr, 1);
    drain("t2");
    check("t2_overflow", overflow, 0);

    // Back-to-back single-bit masks
    pop_ready      = 1'b1;
    push_valid     = 1'b1;
    push_positions = 8'b0000_1000;
    center_addr    = 8'd20;
    @(negedge clk);
    check("t3_ready_a", push_ready, 1);
    model_push(8'd20, 8'b0000_1000);
    step();
    push_positions = 8'b0001_0000;
    center_addr    = 8'd30;
    @(negedge clk);
    check("t3_ready_b", push_ready, 1);
    model_push(8'd30, 8'b0001_0000);
    step();
    push_valid     = 1'b0;
    push_positions = '0;
    @(negedge clk);
    check("t3_pop0_valid", pop_valid, 1);
    check("t3_pop0_addr", pop_addr, 19);
    step();
    @(negedge clk);
    check("t3_pop1_valid", pop_valid, 1);
    check("t3_pop1_addr", pop_addr, 31);
    step();
    drain("t3");

    // Zero mask is a no-op
    push_valid     = 1'b1;
    push_positions = '0;
    center_addr    = 8'd5;
    @(negedge clk);
    check("t4_ready", push_ready, 1);
    step();
    push_valid = 1'b0;
    @(negedge clk);
    check("t4_count", count, 0);
    check("t4_idle", push_ready, 1);
    step();
    check("t4_pop_valid", pop_valid, 0);

    // Flush mid-serialization
    pop_ready = 1'b0;
    push(8'd10, 8'hFF);
    step(); step(); step();
    check("t5_pre_count", count, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    check("t5_count", count, 0);
    check("t5_pop_valid", pop_valid, 0);
    check("t5_push_ready", push_ready, 1);
    step();
    check("t5_no_residue", count, 0);

    // Asynchronous reset mid-serialization
    push(8'd10, 8'hFF);
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_pop_valid", pop_valid, 0);
    check("t6_overflow", overflow, 0);
    check("t6_push_ready", push_ready, 1);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    check("t6_no_residue", count, 0);

    // Randomized traffic with a random consumer
    rand_pop = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        logic [PW-1:0] m;
        m = ($urandom_range(0, 3) == 0) ? '0 : PW'($urandom);
        push(AW'($urandom), m);
      end
    end
    rand_pop = 1'b0;
    step();
    drain("rand");
    check("rand_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
